// File: rtl/cart_rom_fetch.sv
// Two-entry word buffer between a cartridge mapper and a 16-bit external memory.
// Demand misses are fetched, and the next sequential word is prefetched into the non-MRU entry.
module cart_rom_fetch #(
  parameter int ADDR_W = 19
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              loading,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [7:0]        rom_dout,
  output logic              hit,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_din
);

  localparam int TW = ADDR_W - 1;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_PREFETCH = 2'd2;
  localparam logic [TW-1:0] TAG_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] TAG_ONE = {{(TW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [1:0]    valid_q, valid_d;
  logic [TW-1:0] tag_q  [2];
  logic [TW-1:0] tag_d  [2];
  logic [15:0]   data_q [2];
  logic [15:0]   data_d [2];
  logic          mru_q, mru_d;
  logic          req_q, req_d;
  logic [TW-1:0] maddr_q, maddr_d;
  logic [7:0]    dout_q, dout_d;
  logic          hit_q, hit_d;

  logic [TW-1:0] word_s;
  logic          bsel_s;
  logic [1:0]    match_s;
  logic          any_match_s, match_idx_s, victim_s, ack_s, fwd_s;
  logic [15:0]   hit_word_s;
  logic [7:0]    hit_byte_s, fwd_byte_s;
  logic          fill_pf_ok_s, hit_pf_ok_s;

  assign word_s      = addr_in[ADDR_W-1:1];
  assign bsel_s      = addr_in[0];
  assign match_s[0]  = valid_q[0] && (tag_q[0] == word_s);
  assign match_s[1]  = valid_q[1] && (tag_q[1] == word_s);
  assign any_match_s = |match_s;
  assign match_idx_s = ~match_s[0];
  assign victim_s    = ~mru_q;
  assign ack_s       = mem_ack && req_q;
  assign fwd_s       = ack_s && (word_s == maddr_q);
  assign hit_word_s  = data_q[match_idx_s];
  assign hit_byte_s  = bsel_s ? hit_word_s[15:8] : hit_word_s[7:0];
  assign fwd_byte_s  = bsel_s ? mem_din[15:8] : mem_din[7:0];

  // The entry that could already hold tag+1 is always the MRU one in both prefetch cases.
  assign fill_pf_ok_s = (maddr_q != TAG_MAX) &&
                        !(valid_q[mru_q] && (tag_q[mru_q] == maddr_q + TAG_ONE));
  assign hit_pf_ok_s  = (word_s != TAG_MAX) &&
                        !(valid_q[mru_q] && (tag_q[mru_q] == word_s + TAG_ONE));

  // Next-state logic for lookup, fill and request sequencing.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    mru_d   = mru_q;
    req_d   = req_q;
    maddr_d = maddr_q;
    dout_d  = dout_q;
    hit_d   = hit_q;

    if (loading) begin
      valid_d = 2'b00;
      hit_d   = 1'b0;
      if (req_q) begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      if (fwd_s) begin
        hit_d  = 1'b1;
        dout_d = fwd_byte_s;
      end else if (any_match_s) begin
        hit_d  = 1'b1;
        dout_d = hit_byte_s;
      end else begin
        hit_d  = 1'b0;
      end

      if (any_match_s) begin
        mru_d = match_idx_s;
      end else begin
        mru_d = mru_q;
      end

      case (state_q)
        S_IDLE: begin
          if (!any_match_s) begin
            state_d = S_FETCH;
            req_d   = 1'b1;
            maddr_d = word_s;
          end else if ((match_idx_s != mru_q) && hit_pf_ok_s) begin
            state_d = S_PREFETCH;
            req_d   = 1'b1;
            maddr_d = word_s + TAG_ONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          if (ack_s) begin
            valid_d[victim_s] = 1'b1;
            tag_d[victim_s]   = maddr_q;
            data_d[victim_s]  = mem_din;
            mru_d             = victim_s;
            req_d             = 1'b0;
            if (fill_pf_ok_s) begin
              // Request line drops for one cycle; PREFETCH raises it again.
              state_d = S_PREFETCH;
              maddr_d = maddr_q + TAG_ONE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            req_d = 1'b1;
          end
        end
        S_PREFETCH: begin
          if (ack_s) begin
            valid_d[victim_s] = 1'b1;
            tag_d[victim_s]   = maddr_q;
            data_d[victim_s]  = mem_din;
            mru_d             = mru_q;
            req_d             = 1'b0;
            state_d           = S_IDLE;
          end else begin
            req_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      valid_q   <= 2'b00;
      tag_q[0]  <= {TW{1'b0}};
      tag_q[1]  <= {TW{1'b0}};
      data_q[0] <= 16'h0000;
      data_q[1] <= 16'h0000;
      mru_q     <= 1'b0;
      req_q     <= 1'b0;
      maddr_q   <= {TW{1'b0}};
      dout_q    <= 8'h00;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      mru_q     <= mru_d;
      req_q     <= req_d;
      maddr_q   <= maddr_d;
      dout_q    <= dout_d;
      hit_q     <= hit_d;
    end
  end

  assign rom_dout = dout_q;
  assign hit      = hit_q;
  assign mem_req  = req_q;
  assign mem_addr = maddr_q;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Scoreboard bench for cart_rom_fetch: expected request addresses and read bytes are queued
// as stimulus is driven and compared when the DUT raises mem_req or reports a hit.
module tb_cart_rom_fetch;

  localparam int LAT = 3;

  logic        clk_sys;
  logic        reset;
  logic        loading;
  logic [18:0] addr_in;
  logic [7:0]  rom_dout;
  logic        hit;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_din;

  int n_checks = 0;
  int n_err    = 0;
  int unexp_cnt = 0;
  int overlap_cnt = 0;
  int unstable_cnt = 0;
  int lat_cnt = 0;
  logic        prev_req = 1'b0;
  logic [17:0] prev_addr = 18'h0;
  logic        ack_at_edge = 1'b0;
  logic        force_en = 1'b0;
  logic [15:0] force_din = 16'h0000;

  logic [17:0] exp_req_q [$];
  logic [7:0]  exp_data_q [$];

  cart_rom_fetch #(.ADDR_W(19)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .loading (loading),
    .addr_in (addr_in),
    .rom_dout(rom_dout),
    .hit     (hit),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_din (mem_din)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  function automatic logic [15:0] mem_word(input logic [17:0] w);
    if (w == 18'h00008)      return 16'hBEEF;
    else if (w == 18'h3FFFF) return 16'h1234;
    else                     return {w[7:0] ^ 8'h5A, w[7:0] ^ 8'hC3};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: sample after the edge, score requests, then model the memory.
  task automatic tick();
    logic        ack_before;
    logic [17:0] e;
    ack_before = mem_ack;
    @(posedge clk_sys);
    #1;
    ack_at_edge = ack_before;
    if (ack_before && prev_req && mem_req) overlap_cnt++;
    if (mem_req && prev_req && (mem_addr != prev_addr)) unstable_cnt++;
    if (mem_req && !prev_req) begin
      if (exp_req_q.size() > 0) begin
        e = exp_req_q.pop_front();
        check_eq("req_addr", 32'(mem_addr), 32'(e));
      end else begin
        unexp_cnt++;
      end
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
    mem_ack   = 1'b0;
    if (mem_req && !ack_before) begin
      if (lat_cnt == LAT - 1) begin
        mem_ack = 1'b1;
        mem_din = force_en ? force_din : mem_word(mem_addr);
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic dwell(input int n);
    repeat (n) tick();
  endtask

  task automatic read_byte(input logic [18:0] a, input logic [7:0] e, input int bound);
    int n;
    logic [7:0] ex;
    exp_data_q.push_back(e);
    addr_in = a;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hit && n < bound);
    check_eq($sformatf("hit@%05h", a), 32'(hit), 32'(1));
    ex = exp_data_q.pop_front();
    check_eq($sformatf("data@%05h", a), 32'(rom_dout), 32'(ex));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dwell(2);
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    reset   = 1'b1;
    loading = 1'b0;
    addr_in = 19'h0;
    mem_ack = 1'b0;
    mem_din = 16'h0000;

    // Reset state
    dwell(2);
    check_eq("rst_hit", 32'(hit), 32'(0));
    check_eq("rst_dout", 32'(rom_dout), 32'(0));
    check_eq("rst_req", 32'(mem_req), 32'(0));
    check_eq("rst_addr", 32'(mem_addr), 32'(0));
    reset = 1'b0;

    // Cold miss, then demand miss while the prefetch is outstanding
    exp_req_q.push_back(18'h00008);
    addr_in = 19'h00010;
    tick();
    check_eq("cold_req", 32'(mem_req), 32'(1));
    check_eq("cold_addr", 32'(mem_addr), 32'(18'h00008));
    read_byte(19'h00010, 8'hEF, 20);
    check_eq("cold_fwd_at_ack", 32'(ack_at_edge), 32'(1));
    exp_req_q.push_back(18'h00009);
    tick();
    exp_req_q.push_back(18'h20000);
    exp_req_q.push_back(18'h20001);
    read_byte(19'h40000, 8'hC3, 20);
    dwell(8);
    exp_req_q.push_back(18'h20002);
    read_byte(19'h40003, 8'h5B, 1);
    dwell(8);

    // Sequential streaming with a slow consumer
    do_reset();
    exp_req_q.push_back(18'h00008);
    exp_req_q.push_back(18'h00009);
    read_byte(19'h00010, 8'hEF, 20);
    dwell(8);
    read_byte(19'h00011, 8'hBE, 1);
    exp_req_q.push_back(18'h0000A);
    read_byte(19'h00012, 8'hCA, 1);
    dwell(8);
    read_byte(19'h00013, 8'h53, 1);
    exp_req_q.push_back(18'h0000B);
    read_byte(19'h00014, 8'hC9, 1);
    dwell(8);
    read_byte(19'h00015, 8'h50, 1);
    dwell(4);

    // End of address space: no prefetch past the last word
    do_reset();
    exp_req_q.push_back(18'h3FFFF);
    read_byte(19'h7FFFE, 8'h34, 20);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_req) cnt++;
    end
    check_eq("eos_noreq", 32'(cnt), 32'(0));
    read_byte(19'h7FFFF, 8'h12, 1);

    // Loading abort with an outstanding request
    do_reset();
    exp_req_q.push_back(18'h00080);
    addr_in = 19'h00100;
    tick();
    loading   = 1'b1;
    force_en  = 1'b1;
    force_din = 16'hAAAA;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hit) cnt++;
    end
    check_eq("load_hit_cnt", 32'(cnt), 32'(0));
    check_eq("load_req", 32'(mem_req), 32'(0));
    loading  = 1'b0;
    force_en = 1'b0;
    exp_req_q.push_back(18'h00080);
    exp_req_q.push_back(18'h00081);
    tick();
    check_eq("abort_idle_req", 32'(mem_req), 32'(1));
    check_eq("abort_discard", 32'(hit), 32'(0));
    read_byte(19'h00100, 8'h43, 20);
    dwell(8);

    // Stray ack with mem_req low: forwarding and entries must be untouched
    mem_ack = 1'b1;
    mem_din = 16'hFFFF;
    exp_req_q.push_back(18'h00082);
    read_byte(19'h00103, 8'hDB, 1);
    dwell(8);
    read_byte(19'h00102, 8'h42, 1);

    // Reset mid-request, with loading and a stray ack during reset
    do_reset();
    exp_req_q.push_back(18'h00100);
    addr_in = 19'h00200;
    tick();
    reset   = 1'b1;
    loading = 1'b1;
    tick();
    check_eq("midrst_req", 32'(mem_req), 32'(0));
    check_eq("midrst_hit", 32'(hit), 32'(0));
    mem_ack = 1'b1;
    mem_din = 16'hFFFF;
    tick();
    check_eq("rst_ack_hit", 32'(hit), 32'(0));
    check_eq("rst_ack_dout", 32'(rom_dout), 32'(0));
    reset   = 1'b0;
    loading = 1'b0;
    exp_req_q.push_back(18'h00100);
    exp_req_q.push_back(18'h00101);
    read_byte(19'h00200, 8'hC3, 20);
    dwell(8);

    check_eq("unexpected_reqs", 32'(unexp_cnt), 32'(0));
    check_eq("reqs_not_seen", 32'(exp_req_q.size()), 32'(0));
    check_eq("req_overlap", 32'(overlap_cnt), 32'(0));
    check_eq("addr_unstable", 32'(unstable_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cart_rom_fetch.md
CART_ROM_FETCH -- requirements
Module: cart_rom_fetch

Interface
REQ-001 Parameter ADDR_W, default 19: byte-address width of the cartridge ROM space.
REQ-002 Port clk_sys, input, 1: sole clock; every register updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port loading, input, 1: ROM download in progress.
REQ-005 Port addr_in, input, ADDR_W: byte address from the cartridge mapper, sampled every cycle.
REQ-006 Port rom_dout, output, 8: registered byte for addr_in.
REQ-007 Port hit, output, 1: registered flag; rom_dout is valid for the addr_in sampled at the same edge.
REQ-008 Port mem_req, output, 1: level read request to the external 16-bit memory.
REQ-009 Port mem_addr, output, ADDR_W-1: word address of the request.
REQ-010 Port mem_ack, input, 1: one-cycle pulse; mem_din is valid in that cycle.
REQ-011 Port mem_din, input, 16: fetched word; low byte = even address, high byte = odd address.

Function
REQ-012 Block SHALL hold two buffer entries, each with a valid bit, a tag of ADDR_W-1 bits and a 16-bit word, plus one MRU bit.
REQ-013 Word address SHALL be addr_in[ADDR_W-1:1]; byte select SHALL be addr_in[0] (0 = mem_din[7:0]).
REQ-014 Each edge: on a valid-entry tag match, set hit=1, load the selected byte into rom_dout and set MRU to the matching entry.
REQ-015 Each edge with no tag match: set hit=0 and hold rom_dout.
REQ-016 FSM states SHALL be IDLE, FETCH (demand) and PREFETCH.
REQ-017 IDLE, miss, loading=0: at the same edge go to FETCH, set mem_req=1, set mem_addr=missed word.
REQ-018 FETCH/PREFETCH: hold mem_req=1 and mem_addr stable until mem_ack; clear mem_req at the edge that samples mem_ack.
REQ-019 Demand fill SHALL write the non-MRU entry and make it MRU.
REQ-020 Same edge as a demand fill: if addr_in matches the filled word, set hit=1 and take rom_dout from mem_din (forwarding, no extra cycle).
REQ-021 After a demand fill, go to PREFETCH for tag+1 if tag+1 is not already valid in the other entry and tag is not all-ones. Otherwise return to IDLE.
REQ-022 Prefetch fill SHALL write the non-MRU entry, leave MRU unchanged, then return to IDLE. Forwarding per REQ-020 SHALL also apply.
REQ-023 IDLE, hit on the entry that was not MRU: if its tag+1 is absent and its tag is not all-ones, go to PREFETCH for tag+1.
REQ-024 A demand miss during PREFETCH SHALL NOT abort the request. After the prefetch ack, return to IDLE; the miss is then re-evaluated per REQ-017.
REQ-025 mem_ack sampled while mem_req=0 SHALL be ignored.
REQ-026 loading=1 SHALL clear both valid bits every cycle, force hit=0 and block new requests.
REQ-027 loading=1 with a request outstanding: keep mem_req until mem_ack, discard mem_din, then go to IDLE.
REQ-028 Tag+1 SHALL NOT wrap: no prefetch is ever issued past word 2^(ADDR_W-1)-1.

Reset
REQ-029 Reset SHALL set state=IDLE, both valid bits=0, MRU=0, mem_req=0, mem_addr=0, rom_dout=0x00, hit=0.
REQ-030 Reset mid-request SHALL drop mem_req at the next edge, and a following mem_ack SHALL be ignored.
REQ-031 Reset SHALL take priority over loading and over mem_ack in the same cycle.

Verification
REQ-032 Cold miss: after reset, addr_in=0x00010, memory returns 0xBEEF after 3 cycles. Required: mem_req=1 the cycle after sampling, mem_addr=0x00008; at the ack edge hit=1, rom_dout=0xEF; then a prefetch request for mem_addr=0x00009.
REQ-033 Sequential streaming: addr_in steps 0x00010 to 0x00015 with prefetch acks available. Required: each prefetch request is issued after the prior fill completes, and every byte from the prefetched word comes out with hit=1.
REQ-034 Miss during prefetch: while the 0x00009 prefetch is outstanding, set addr_in=0x40000. Required: the prefetch completes first, then a demand request for mem_addr=0x20000; no second request overlaps the first.
REQ-035 End of space: addr_in=0x7FFFE miss, ack 0x1234. Required: rom_dout=0x34, hit=1, and no prefetch (mem_req stays 0).
REQ-036 Loading abort: raise loading during an outstanding request, then ack 0xAAAA. Required: hit stays 0, data is discarded, state is IDLE, and no request is issued while loading=1.
REQ-037 Stray ack: pulse mem_ack with mem_req=0. Required: no change to the entries, hit or rom_dout.
